// File: rtl/cdf_store_packer.sv
// Store stage at the tail of the CDF pipeline: packs per-element results into
// lane-masked memory words and issues them over a valid/ready write port.
module cdf_store_packer #(
   parameter int RESULT_WIDTH = 20,
   parameter int LANE_WIDTH   = 32,
   parameter int BUS_WIDTH    = 128,
   parameter int ADDR_WIDTH   = 16
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                StartIn,
   input  logic [RESULT_WIDTH-1:0]             ResultIn,
   input  logic [ADDR_WIDTH-1:0]               StoreAddressIn,
   input  logic                                FlushIn,
   output logic                                ReadyOut,
   output logic [BUS_WIDTH-1:0]                WriteBus,
   output logic [ADDR_WIDTH-1:0]               WriteAddress,
   output logic [BUS_WIDTH/LANE_WIDTH-1:0]     WriteLaneMask,
   output logic                                WriteEnable,
   input  logic                                WriteReady,
   output logic                                Idle,
   output logic [15:0]                         WordsWritten
);
   localparam int LANES = BUS_WIDTH / LANE_WIDTH;
   localparam int LB    = $clog2(LANES);
   localparam int LBW   = (LB > 0) ? LB : 1;

   logic                  buf_valid_q, buf_valid_d;
   logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
   logic [LANES-1:0]      buf_mask_q, buf_mask_d;
   logic [BUS_WIDTH-1:0]  buf_data_q, buf_data_d;

   logic [BUS_WIDTH-1:0]  wbus_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [LANES-1:0]      wmask_q;
   logic                  we_q;
   logic [15:0]           words_q;

   logic                  out_free, accept, emit;
   logic [LBW-1:0]        lane;
   logic [ADDR_WIDTH-1:0] word;
   logic [LANES-1:0]      lane_onehot, merged_mask, emit_mask;
   logic [BUS_WIDTH-1:0]  elem_word, lane_bits, merged_data, emit_data;
   logic [ADDR_WIDTH-1:0] emit_addr;

   assign out_free = !we_q || WriteReady;
   assign ReadyOut = out_free && !FlushIn;
   assign accept   = StartIn && ReadyOut;

   // With a single lane per word there are no lane bits in the address.
   assign lane = (LB > 0) ? StoreAddressIn[LBW-1:0] : '0;
   assign word = StoreAddressIn >> LB;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_onehot[gi] = (lane == LBW'(gi));
      assign elem_word[gi*LANE_WIDTH +: LANE_WIDTH] =
         lane_onehot[gi] ? LANE_WIDTH'(ResultIn) : '0;
      assign lane_bits[gi*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{lane_onehot[gi]}};
   end

   // Replacing the whole lane makes a repeated lane simply overwrite (last write wins).
   assign merged_data = (buf_data_q & ~lane_bits) | elem_word;
   assign merged_mask = buf_mask_q | lane_onehot;

   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      buf_mask_d  = buf_mask_q;
      buf_data_d  = buf_data_q;
      emit        = 1'b0;
      emit_addr   = buf_addr_q;
      emit_mask   = buf_mask_q;
      emit_data   = buf_data_q;
      if (accept) begin
         if (buf_valid_q && (word == buf_addr_q)) begin
            if (&merged_mask) begin
               emit        = 1'b1;
               emit_mask   = merged_mask;
               emit_data   = merged_data;
               buf_valid_d = 1'b0;
               buf_mask_d  = '0;
               buf_data_d  = '0;
            end else begin
               buf_mask_d = merged_mask;
               buf_data_d = merged_data;
            end
         end else if (buf_valid_q) begin
            emit       = 1'b1;
            buf_addr_d = word;
            buf_mask_d = lane_onehot;
            buf_data_d = elem_word;
         end else if (LANES == 1) begin
            emit      = 1'b1;
            emit_addr = word;
            emit_mask = lane_onehot;
            emit_data = elem_word;
         end else begin
            buf_valid_d = 1'b1;
            buf_addr_d  = word;
            buf_mask_d  = lane_onehot;
            buf_data_d  = elem_word;
         end
      end else if (FlushIn && out_free && buf_valid_q) begin
         emit        = 1'b1;
         buf_valid_d = 1'b0;
         buf_mask_d  = '0;
         buf_data_d  = '0;
      end
   end

   // Emits only happen while out_free, so loading never overwrites a stalled word.
   always_ff @(posedge clock) begin
      if (reset) begin
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_mask_q  <= '0;
         buf_data_q  <= '0;
         wbus_q      <= '0;
         waddr_q     <= '0;
         wmask_q     <= '0;
         we_q        <= 1'b0;
         words_q     <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_mask_q  <= buf_mask_d;
         buf_data_q  <= buf_data_d;
         if (emit) begin
            wbus_q  <= emit_data;
            waddr_q <= emit_addr;
            wmask_q <= emit_mask;
            we_q    <= 1'b1;
         end else if (WriteReady) begin
            we_q <= 1'b0;
         end
         if (we_q && WriteReady) begin
            words_q <= words_q + 16'd1;
         end
      end
   end

   assign WriteBus      = wbus_q;
   assign WriteAddress  = waddr_q;
   assign WriteLaneMask = wmask_q;
   assign WriteEnable   = we_q;
   assign WordsWritten  = words_q;
   assign Idle          = !buf_valid_q && !we_q;

endmodule

// File: tb/tb_cdf_store_packer.sv
// Bench for cdf_store_packer: vector table plus hand sequences, with expected
// writes queued at stimulus time and compared when each write handshake occurs.
module tb_cdf_store_packer;
   localparam int RW = 20;
   localparam int LW = 32;
   localparam int BW = 128;
   localparam int AW = 16;
   localparam int L  = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          StartIn = 1'b0;
   logic [RW-1:0] ResultIn = '0;
   logic [AW-1:0] StoreAddressIn = '0;
   logic          FlushIn = 1'b0;
   logic          ReadyOut;
   logic [BW-1:0] WriteBus;
   logic [AW-1:0] WriteAddress;
   logic [L-1:0]  WriteLaneMask;
   logic          WriteEnable;
   logic          WriteReady = 1'b1;
   logic          Idle;
   logic [15:0]   WordsWritten;

   cdf_store_packer #(
      .RESULT_WIDTH(RW), .LANE_WIDTH(LW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)
   ) dut (
      .clock(clock), .reset(reset), .StartIn(StartIn), .ResultIn(ResultIn),
      .StoreAddressIn(StoreAddressIn), .FlushIn(FlushIn), .ReadyOut(ReadyOut),
      .WriteBus(WriteBus), .WriteAddress(WriteAddress), .WriteLaneMask(WriteLaneMask),
      .WriteEnable(WriteEnable), .WriteReady(WriteReady), .Idle(Idle),
      .WordsWritten(WordsWritten)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [AW-1:0] addr;
      logic [L-1:0]  mask;
      logic [BW-1:0] data;
   } wr_t;

   typedef struct {
      bit            start;
      logic [AW-1:0] addr;
      logic [RW-1:0] res;
      bit            flush;
      bit            exp_ready;
      bit            emit;
      logic [AW-1:0] eaddr;
      logic [L-1:0]  emask;
      logic [BW-1:0] edata;
   } vec_t;

   wr_t   exp_q[$];
   int    n_vec = 0;
   int    n_bad = 0;
   int    n_pushed = 0;
   vec_t  tbl[14];

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit start, input logic [AW-1:0] addr, input logic [RW-1:0] res,
                               input bit flush, input bit exp_ready, input bit emit,
                               input logic [AW-1:0] eaddr, input logic [L-1:0] emask,
                               input logic [BW-1:0] edata);
      vec_t v;
      v.start = start; v.addr = addr; v.res = res; v.flush = flush; v.exp_ready = exp_ready;
      v.emit = emit; v.eaddr = eaddr; v.emask = emask; v.edata = edata;
      return v;
   endfunction

   // Write monitor: one handshake per cycle, compared against the queue head.
   always @(negedge clock) begin
      if (!reset && WriteEnable && WriteReady) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {{(BW-AW){1'b0}}, WriteAddress}, '1);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", BW'(WriteAddress), BW'(e.addr));
            check("write_mask", BW'(WriteLaneMask), BW'(e.mask));
            check("write_data", WriteBus, e.data);
            $display("write addr=0x%0h mask=%b data=0x%032h", WriteAddress, WriteLaneMask, WriteBus);
         end
      end
   end

   task automatic push_exp(input logic [AW-1:0] a, input logic [L-1:0] m, input logic [BW-1:0] d);
      wr_t e;
      e.addr = a; e.mask = m; e.data = d;
      exp_q.push_back(e);
      n_pushed++;
   endtask

   task automatic apply_vec(input vec_t v, input string name);
      @(posedge clock); #1;
      StartIn = v.start; StoreAddressIn = v.addr; ResultIn = v.res; FlushIn = v.flush;
      @(negedge clock);
      check({name, "_ready"}, BW'(ReadyOut), BW'(v.exp_ready));
      if (v.emit) push_exp(v.eaddr, v.emask, v.edata);
      $display("vec %s start=%0b addr=0x%0h res=0x%0h flush=%0b ready=%0b", name,
               v.start, v.addr, v.res, v.flush, ReadyOut);
   endtask

   task automatic quiet();
      @(posedge clock); #1;
      StartIn = 1'b0; FlushIn = 1'b0;
   endtask

   task automatic drain();
      quiet();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
      @(negedge clock);
      check("drain_pending", BW'(exp_q.size()), '0);
   endtask

   initial begin
      tbl[0]  = mk(1, 16'd5,  20'hFFFFF, 0, 1, 0, '0, '0, '0);
      tbl[1]  = mk(0, 16'd0,  20'h0,     1, 0, 1, 16'd1, 4'b0010, 128'h00000000_00000000_000FFFFF_00000000);
      tbl[2]  = mk(1, 16'd8,  20'h1,     0, 1, 0, '0, '0, '0);
      tbl[3]  = mk(1, 16'd20, 20'h2,     0, 1, 1, 16'd2, 4'b0001, 128'h1);
      tbl[4]  = mk(0, 16'd0,  20'h0,     0, 1, 0, '0, '0, '0);
      tbl[5]  = mk(0, 16'd0,  20'h0,     1, 0, 1, 16'd5, 4'b0001, 128'h2);
      tbl[6]  = mk(1, 16'd2,  20'h1,     0, 1, 0, '0, '0, '0);
      tbl[7]  = mk(1, 16'd2,  20'h2,     0, 1, 0, '0, '0, '0);
      tbl[8]  = mk(0, 16'd0,  20'h0,     1, 0, 1, 16'd0, 4'b0100, 128'h00000000_00000002_00000000_00000000);
      tbl[9]  = mk(0, 16'd0,  20'h0,     1, 0, 0, '0, '0, '0);
      tbl[10] = mk(1, 16'd7,  20'h3,     1, 0, 0, '0, '0, '0);
      tbl[11] = mk(0, 16'd0,  20'h0,     1, 0, 0, '0, '0, '0);
      tbl[12] = mk(1, 16'hFFFF, 20'h9,   0, 1, 0, '0, '0, '0);
      tbl[13] = mk(0, 16'd0,  20'h0,     1, 0, 1, 16'h3FFF, 4'b1000, 128'h00000009_00000000_00000000_00000000);

      // Reset state
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_we", BW'(WriteEnable), '0);
      check("rst_bus", WriteBus, '0);
      check("rst_addr", BW'(WriteAddress), '0);
      check("rst_mask", BW'(WriteLaneMask), '0);
      check("rst_words", BW'(WordsWritten), '0);
      check("rst_idle", BW'(Idle), BW'(1));
      check("rst_ready", BW'(ReadyOut), BW'(1));

      // Full word: emit on 4th accept, visible one edge later
      apply_vec(mk(1, 16'd0, 20'h00011, 0, 1, 0, '0, '0, '0), "full0");
      apply_vec(mk(1, 16'd1, 20'h00022, 0, 1, 0, '0, '0, '0), "full1");
      apply_vec(mk(1, 16'd2, 20'h00033, 0, 1, 0, '0, '0, '0), "full2");
      check("full_no_early_we", BW'(WriteEnable), '0);
      apply_vec(mk(1, 16'd3, 20'h00044, 0, 1, 1, 16'd0, 4'b1111,
                   128'h00000044_00000033_00000022_00000011), "full3");
      check("full_no_early_we3", BW'(WriteEnable), '0);
      quiet();
      @(negedge clock);
      check("full_latency_we", BW'(WriteEnable), BW'(1));
      @(negedge clock);
      check("full_we_clear", BW'(WriteEnable), '0);
      check("full_words", BW'(WordsWritten), BW'(1));
      check("full_idle", BW'(Idle), BW'(1));

      // Table: partial/flush, address jump, duplicate lane, blocked start, wrap
      for (int i = 0; i < 14; i++) begin
         apply_vec(tbl[i], $sformatf("tbl%0d", i));
         if (i == 3) check("jump_not_idle", BW'(Idle), '0);
      end
      drain();
      check("tbl_idle", BW'(Idle), BW'(1));
      check("tbl_words", BW'(WordsWritten), BW'(n_pushed));

      // Backpressure: stalled write holds the bus and blocks input
      #1 WriteReady = 1'b0;
      for (int i = 0; i < 4; i++)
         apply_vec(mk(1, AW'(16 + i), RW'(32'h40 + i), 0, 1, i == 3, 16'd4, 4'b1111,
                      128'h00000043_00000042_00000041_00000040), $sformatf("bp%0d", i));
      @(posedge clock); #1;
      StartIn = 1'b1; StoreAddressIn = 16'd24; ResultIn = 20'h5;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("bp_ready_low", BW'(ReadyOut), '0);
         check("bp_we_held", BW'(WriteEnable), BW'(1));
         check("bp_bus_held", WriteBus, 128'h00000043_00000042_00000041_00000040);
         check("bp_addr_held", BW'(WriteAddress), BW'(4));
      end
      @(posedge clock); #1;
      StartIn = 1'b0; WriteReady = 1'b1;
      @(negedge clock);
      check("bp_ready_back", BW'(ReadyOut), BW'(1));
      @(negedge clock);
      check("bp_words", BW'(WordsWritten), BW'(n_pushed));
      check("bp_we_clear", BW'(WriteEnable), '0);
      drain();

      // Reset mid-operation discards three buffered lanes
      for (int i = 0; i < 3; i++)
         apply_vec(mk(1, AW'(32 + i), RW'(i + 1), 0, 1, 0, '0, '0, '0), $sformatf("rstmid%0d", i));
      @(posedge clock); #1;
      StartIn = 1'b0; reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0; n_pushed = 0;
      @(negedge clock);
      check("rstmid_we", BW'(WriteEnable), '0);
      check("rstmid_bus", WriteBus, '0);
      check("rstmid_mask", BW'(WriteLaneMask), '0);
      check("rstmid_words", BW'(WordsWritten), '0);
      check("rstmid_idle", BW'(Idle), BW'(1));
      apply_vec(mk(1, 16'd35, 20'h7, 0, 1, 0, '0, '0, '0), "fresh0");
      apply_vec(mk(0, 16'd0, 20'h0, 1, 0, 1, 16'd8, 4'b1000,
                   128'h00000007_00000000_00000000_00000000), "fresh_flush");
      drain();
      check("fresh_words", BW'(WordsWritten), BW'(1));
      check("fresh_idle", BW'(Idle), BW'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
